// File: rtl/matrix_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_alu_seq
// Function : Sequential signed matrix ALU (add/sub/mul/transpose/neg/scalar)
//            with saturation, sticky overflow and start/done handshake.
// Revision : 1.0
// ============================================================================
module matrix_alu_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       size,
  input  logic [W-1:0]     data_escalar,
  input  logic [N*N*W-1:0] matrizA,
  input  logic [N*N*W-1:0] matrizB,
  output logic [N*N*W-1:0] matriz_resultante,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             error
);

  localparam int c_AW   = 2*W + 4;
  localparam int c_MAXI = (1 << (W-1)) - 1;
  localparam int c_MINI = -(1 << (W-1));
  localparam logic signed [c_AW-1:0] c_MAX = c_AW'(c_MAXI);
  localparam logic signed [c_AW-1:0] c_MIN = c_AW'(c_MINI);

  localparam logic [3:0] c_OP_ADD = 4'b0011;
  localparam logic [3:0] c_OP_SUB = 4'b0100;
  localparam logic [3:0] c_OP_MUL = 4'b0101;
  localparam logic [3:0] c_OP_TRN = 4'b0110;
  localparam logic [3:0] c_OP_NEG = 4'b0111;
  localparam logic [3:0] c_OP_SCL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [3:0]               r_op;
  logic [3:0]               r_size;
  logic [W-1:0]             r_scalar;
  logic [N*N*W-1:0]         r_a;
  logic [N*N*W-1:0]         r_b;
  logic [N*N*W-1:0]         r_res;
  logic                     r_overflow;
  logic                     r_error;
  logic [3:0]               r_row;
  logic [3:0]               r_col;
  logic [3:0]               r_k;
  logic signed [c_AW-1:0]   r_acc;

  logic                     w_req_ok;
  logic [3:0]               w_last;
  logic                     w_is_mul;
  logic                     w_write;
  logic                     w_final;
  int                       w_i_rc;
  int                       w_i_cr;
  int                       w_i_rk;
  int                       w_i_kc;
  logic signed [c_AW-1:0]   w_a_ext;
  logic signed [c_AW-1:0]   w_at_ext;
  logic signed [c_AW-1:0]   w_b_ext;
  logic signed [c_AW-1:0]   w_s_ext;
  logic signed [c_AW-1:0]   w_ma_ext;
  logic signed [c_AW-1:0]   w_mb_ext;
  logic signed [c_AW-1:0]   w_acc_next;
  logic signed [c_AW-1:0]   w_wide;
  logic [W-1:0]             w_sat;
  logic                     w_sat_ovf;

  assign w_req_ok = (opcode >= c_OP_ADD) && (opcode <= c_OP_SCL) &&
                    (size != 4'd0) && (size <= 4'(N));
  assign w_last   = r_size - 4'd1;
  assign w_is_mul = (r_op == c_OP_MUL);
  assign w_write  = !w_is_mul || (r_k == w_last);
  assign w_final  = (r_row == w_last) && (r_col == w_last) && w_write;

  // Operand fetch and the wide pre-saturation value for the current index.
  always_comb begin
    w_i_rc   = (int'(r_row) * N + int'(r_col)) * W;
    w_i_cr   = (int'(r_col) * N + int'(r_row)) * W;
    w_i_rk   = (int'(r_row) * N + int'(r_k)) * W;
    w_i_kc   = (int'(r_k) * N + int'(r_col)) * W;
    w_a_ext  = c_AW'($signed(r_a[w_i_rc +: W]));
    w_at_ext = c_AW'($signed(r_a[w_i_cr +: W]));
    w_b_ext  = c_AW'($signed(r_b[w_i_rc +: W]));
    w_s_ext  = c_AW'($signed(r_scalar));
    w_ma_ext = c_AW'($signed(r_a[w_i_rk +: W]));
    w_mb_ext = c_AW'($signed(r_b[w_i_kc +: W]));
    w_acc_next = ((r_k == 4'd0) ? '0 : r_acc) + w_ma_ext * w_mb_ext;
    w_wide = '0;
    case (r_op)
      c_OP_ADD: w_wide = w_a_ext + w_b_ext;
      c_OP_SUB: w_wide = w_a_ext - w_b_ext;
      c_OP_MUL: w_wide = w_acc_next;
      c_OP_TRN: w_wide = w_at_ext;
      c_OP_NEG: w_wide = -w_a_ext;
      c_OP_SCL: w_wide = w_a_ext * w_s_ext;
      default:  w_wide = '0;
    endcase
    w_sat_ovf = 1'b0;
    w_sat     = w_wide[W-1:0];
    if (w_wide > c_MAX) begin
      w_sat     = c_MAX[W-1:0];
      w_sat_ovf = 1'b1;
    end else if (w_wide < c_MIN) begin
      w_sat     = c_MIN[W-1:0];
      w_sat_ovf = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_req_ok ? S_RUN : S_DONE;
      S_RUN:   if (w_final) w_state_next = S_DONE;
      S_DONE:  if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_size     <= '0;
      r_scalar   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_acc      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_op       <= opcode;
          r_size     <= size;
          r_scalar   <= data_escalar;
          r_a        <= matrizA;
          r_b        <= matrizB;
          r_res      <= '0;
          r_overflow <= 1'b0;
          r_error    <= !w_req_ok;
          r_row      <= '0;
          r_col      <= '0;
          r_k        <= '0;
          r_acc      <= '0;
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (w_write) begin
            r_res[w_i_rc +: W] <= w_sat;
            r_overflow         <= r_overflow | w_sat_ovf;
          end
          // k innermost (multiply only), then column, then row.
          if (w_is_mul && (r_k != w_last)) begin
            r_k <= r_k + 4'd1;
          end else begin
            r_k <= '0;
            if (r_col != w_last) begin
              r_col <= r_col + 4'd1;
            end else begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign matriz_resultante = r_res;
  assign done              = (r_state == S_DONE);
  assign busy              = (r_state == S_RUN);
  assign overflow          = r_overflow;
  assign error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_matrix_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_alu_seq
// Function : Directed self-checking bench for matrix_alu_seq.
// Revision : 1.0
// ============================================================================
module tb_matrix_alu_seq;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int VW = N*N*W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    opcode;
  logic [3:0]    size;
  logic [W-1:0]  data_escalar;
  logic [VW-1:0] matrizA;
  logic [VW-1:0] matrizB;
  logic [VW-1:0] res;
  logic          done;
  logic          busy;
  logic          overflow;
  logic          error;

  int            checks   = 0;
  int            failures = 0;
  logic [VW-1:0] exp_res;
  logic          exp_ovf;
  logic          exp_err;
  logic          exp_valid = 1'b0;
  logic [VW-1:0] last_res;
  logic          last_ovf;

  matrix_alu_seq #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .size(size),
    .data_escalar(data_escalar), .matrizA(matrizA), .matrizB(matrizB),
    .matriz_resultante(res), .done(done), .busy(busy),
    .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int el(input logic [VW-1:0] m, input int i, input int j);
    return int'($signed(m[(i*N+j)*W +: W]));
  endfunction

  function automatic logic [VW-1:0] put(input logic [VW-1:0] m, input int i, input int j, input int v);
    logic [VW-1:0] t;
    t = m;
    t[(i*N+j)*W +: W] = W'(v);
    return t;
  endfunction

  // Reference: plain integer matrix arithmetic followed by clamping.
  function automatic void model(input logic [3:0] op, input logic [3:0] sz, input logic [W-1:0] s,
                                input logic [VW-1:0] a, input logic [VW-1:0] b,
                                output logic [VW-1:0] r, output logic ovf, output logic err);
    int maxv, minv, v, n;
    maxv = (1 << (W-1)) - 1;
    minv = -(1 << (W-1));
    r = '0;
    ovf = 1'b0;
    n = int'(sz);
    err = !(op inside {[4'd3:4'd8]}) || n == 0 || n > N;
    if (err) return;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (op)
          4'd3: v = el(a, i, j) + el(b, i, j);
          4'd4: v = el(a, i, j) - el(b, i, j);
          4'd5: begin
            v = 0;
            for (int k = 0; k < n; k++) v += el(a, i, k) * el(b, k, j);
          end
          4'd6: v = el(a, j, i);
          4'd7: v = -el(a, i, j);
          default: v = el(a, i, j) * int'($signed(s));
        endcase
        if (v > maxv) begin v = maxv; ovf = 1'b1; end
        else if (v < minv) begin v = minv; ovf = 1'b1; end
        r = put(r, i, j, v);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (exp_valid && done) begin
      check_vec("result", res, exp_res);
      check_int("overflow", longint'(overflow), longint'(exp_ovf));
      check_int("error", longint'(error), longint'(exp_err));
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [3:0] sz, input logic [W-1:0] s,
                        input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input int exp_lat, input int hold);
    int cnt;
    logic seen;
    model(op, sz, s, a, b, exp_res, exp_ovf, exp_err);
    exp_valid = 1'b1;
    @(negedge clk);
    opcode = op; size = sz; data_escalar = s; matrizA = a; matrizB = b; start = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check_int("busy_in_run", longint'(busy), 1);
        if (cnt == 1) begin
          matrizA = ~matrizA; matrizB = ~matrizB; opcode = 4'h5;
          size = 4'd5; data_escalar = ~data_escalar;
        end
      end
    end
    check_int("latency", cnt, exp_lat);
    check_int("busy_at_done", longint'(busy), 0);
    last_res = res;
    last_ovf = overflow;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_int("done_held", longint'(done), 1);
      check_int("no_retrigger", longint'(busy), 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check_int("done_drop", longint'(done), 0);
    exp_valid = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] a, b;
    reset = 1'b1; start = 1'b0; opcode = '0; size = '0; data_escalar = '0;
    matrizA = '0; matrizB = '0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_res", res, '0);
    check_int("reset_done", longint'(done), 0);
    check_int("reset_busy", longint'(busy), 0);
    check_int("reset_ovf", longint'(overflow), 0);
    check_int("reset_err", longint'(error), 0);
    @(negedge clk);
    reset = 1'b0;

    // Add 2x2, then hold start to confirm no retrigger.
    a = '0; b = '0;
    a = put(a,0,0,1); a = put(a,0,1,2); a = put(a,1,0,3); a = put(a,1,1,4);
    b = put(b,0,0,10); b = put(b,0,1,20); b = put(b,1,0,30); b = put(b,1,1,40);
    run_op(4'b0011, 4'd2, '0, a, b, 5, 10);
    check_int("add_00", el(last_res,0,0), 11);
    check_int("add_11", el(last_res,1,1), 44);
    check_int("add_02", el(last_res,0,2), 0);
    check_int("add_ovf", longint'(last_ovf), 0);

    // Multiply 3x3: 2I x {1..9}
    a = '0; b = '0;
    for (int i = 0; i < 3; i++) begin
      a = put(a, i, i, 2);
      for (int j = 0; j < 3; j++) b = put(b, i, j, i*3 + j + 1);
    end
    run_op(4'b0101, 4'd3, '0, a, b, 28, 0);
    check_int("mul_22", el(last_res,2,2), 18);
    check_int("mul_01", el(last_res,0,1), 4);

    // Saturation corner cases, size 1
    run_op(4'b0011, 4'd1, '0, put('0,0,0,100), put('0,0,0,100), 2, 0);
    check_int("sat_add", el(last_res,0,0), 127);
    check_int("sat_add_ovf", longint'(last_ovf), 1);
    run_op(4'b0100, 4'd1, '0, put('0,0,0,-100), put('0,0,0,100), 2, 0);
    check_int("sat_sub", el(last_res,0,0), -128);
    run_op(4'b0111, 4'd1, '0, put('0,0,0,-128), '0, 2, 0);
    check_int("sat_neg", el(last_res,0,0), 127);
    run_op(4'b1000, 4'd1, 8'd16, put('0,0,0,16), '0, 2, 0);
    check_int("sat_scl", el(last_res,0,0), 127);
    check_int("sat_scl_ovf", longint'(last_ovf), 1);

    // Scalar -3 over a signed 4x4 matrix, and signed multiply 4x4
    a = '0; b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a = put(a, i, j, i*11 - j*7 - 5);
        b = put(b, i, j, j*3 - i*2 + 1);
      end
    run_op(4'b1000, 4'd4, 8'hFD, a, b, 17, 0);
    check_int("scl_33", el(last_res,3,3), -3*(33-21-5));
    run_op(4'b0101, 4'd4, '0, a, b, 65, 0);

    // Error cases
    run_op(4'b1111, 4'd2, '0, a, b, 1, 0);
    check_vec("err_op_res", last_res, '0);
    run_op(4'b0011, 4'd6, '0, a, b, 1, 0);

    // Reset in the middle of a 5x5 multiply
    @(negedge clk);
    opcode = 4'b0101; size = 4'd5; matrizA = a; matrizB = b; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_int("mid_busy", longint'(busy), 1);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check_int("rst_busy", longint'(busy), 0);
    check_int("rst_done", longint'(done), 0);
    check_vec("rst_res", res, '0);
    // Reset coinciding with start
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check_int("rst_start_busy", longint'(busy), 0);
    check_int("rst_start_done", longint'(done), 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    // Transpose 5x5 after reset
    a = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) a = put(a, i, j, i*10 + j);
    run_op(4'b0110, 4'd5, '0, a, '0, 26, 0);
    check_int("trn_01", el(last_res,0,1), 10);
    check_int("trn_43", el(last_res,4,3), 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/matrix_alu_seq.md
# matrix_alu_seq

Parametrised, sequential successor to the coprocessor's matrix ALU. It performs signed element-wise and matrix-product operations on square matrices of run-time-selectable size up to N×N. Results are saturated, with a sticky overflow flag and explicit error reporting. It sits between the instruction decoder and the matrix register bank, and uses the same level-sensitive start/done handshake as the existing ALU.

## Interface
- N, default 5: maximum matrix dimension (2..8).
- W, default 8: element width in bits; signed two's complement.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; level-sensitive, held high until done is seen.
- opcode  in  4  0011 add, 0100 sub, 0101 multiply, 0110 transpose(A), 0111 negate(A), 1000 scalar×A; all other values are invalid.
- size  in  4  active dimension, 1..N.
- data_escalar  in  W  scalar operand for opcode 1000.
- matrizA, matrizB  in  N*N*W  operands; element (r,c) at bits [(r*N+c)*W +: W].
- matriz_resultante  out  N*N*W  result, same packing.
- done  out  1  result valid.
- busy  out  1  operation in progress.
- overflow  out  1  at least one element of this result saturated.
- error  out  1  invalid opcode or size.

## Operation
- Reset: synchronous, active-high.
- FSM states are IDLE, RUN and DONE. Reset forces IDLE from any state, including mid-RUN. On reset, matriz_resultante=0, done=0, busy=0, overflow=0, error=0, and all counters are 0.
- IDLE→RUN: on an edge with start=1.
  - opcode, size, data_escalar, matrizA and matrizB are latched into internal registers.
  - matriz_resultante is cleared to 0; overflow and error are cleared.
- IDLE→DONE directly: if opcode is invalid, or size=0, or size>N.
  - error is set to 1; the result stays 0.
- RUN: one index step per cycle; row r, column c (and k for multiply) iterate 0..size-1, with k innermost, then c, then r.
  - Element-wise ops (add, sub, transpose, negate, scalar): one output element per cycle.
  - Multiply: one MAC per cycle into an accumulator of 2W+4 bits. The accumulator is cleared when k=0. At k=size-1 the saturated sum is written to element (r,c).
  - Transpose: R(r,c)=A(c,r), with no arithmetic. Negate: R=−A; −(−2^(W-1)) saturates to 2^(W-1)−1.
  - Add and sub are computed at W+1 bits; scalar at 2W bits. All results then saturate to [−2^(W-1), 2^(W-1)−1].
  - Any saturation sets overflow, which then stays set until the next accept.
  - Elements with r≥size or c≥size remain 0.
- RUN→DONE: on the edge that processes the final index.
- DONE: done=1, and the result and flags are held. DONE→IDLE when start=0 (done drops on that edge).
- Inputs are ignored outside the accept edge. Operand or opcode changes during RUN or DONE have no effect.
- start held high continuously after done does not retrigger; a new request requires start to go low first.

## Timing
- busy=1 exactly in RUN.
- Latency, counted from the accepting edge to the edge on which done rises:
  - Element-wise ops: size²+1 cycles.
  - Multiply: size³+1 cycles.
  - Error case: 1 cycle.
- matriz_resultante is stable and complete whenever done=1. While busy, it is partially updated and not valid.
- Reset asserted on the same edge as start: reset wins, and the FSM stays in IDLE.
- Minimum gap between operations: 1 cycle with start=0.
- The datapath is a single registered stage; there are no combinational paths from inputs to outputs.

## Test plan
- Add, N=5, W=8, size=2:
  - A = {1,2;3,4}, B = {10,20;30,40} → done after 5 cycles, R = {11,22;33,44}, overflow=0, all other elements 0.
- Multiply, size=3:
  - A = identity×2, B = {1..9 row-major} → done after 28 cycles, R = {2,4,6;8,10,12;14,16,18}.
- Saturation:
  - Add 100+100 → 127, overflow=1.
  - Sub −100−100 → −128, overflow=1.
  - Negate −128 → 127, overflow=1.
  - Scalar 16×16 → 127, overflow=1.
- Errors:
  - opcode=1111 → done after 1 cycle, error=1, R=0.
  - size=6 with N=5 → done after 1 cycle, error=1.
- Handshake:
  - Hold start high after done → no retrigger, and R is stable for 10 cycles.
  - Drop start → done=0 on the next edge.
  - Change matrizA during RUN → result unaffected.
- Reset mid-RUN:
  - Assert reset at cycle 10 of a size=5 multiply → next edge gives busy=0, done=0, R=0.
  - A following transpose of size=5 completes correctly after 26 cycles.
